// File: rtl/alu_pipe_if.sv
// Handshake and operand/result bundle for alu_pipe.
// master drives operations and ready_in; slave is the ALU pipeline.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 6
);
  logic [2:0]       op_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] sa_in;
  logic [WIDTH-1:0] sb_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             ovf_out;
  logic             zero_out;

  modport master (
    output op_in, valid_in, sa_in, sb_in, ready_in,
    input  ready_out, valid_out, out, carry_out, ovf_out, zero_out
  );

  modport slave (
    input  op_in, valid_in, sa_in, sb_in, ready_in,
    output ready_out, valid_out, out, carry_out, ovf_out, zero_out
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: STAGES-deep elastic ALU pipeline (stage 1 computes, later stages buffer).
// Optional macro ALU_PIPE_SAT_EN makes add/sub saturate on signed overflow.
module alu_pipe #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  localparam logic [WIDTH:0] SHIFT_LIMIT = (WIDTH+1)'(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             zero;
  } res_t;

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  dif;
  logic            a_msb;
  logic            b_msb;
  logic            shift_big;
  res_t            alu_c;
  logic [STAGES:1] vld;
  logic [STAGES:1] ld;
  res_t            stg [1:STAGES];

  assign a_msb     = bus.sa_in[WIDTH-1];
  assign b_msb     = bus.sb_in[WIDTH-1];
  assign sum       = {1'b0, bus.sa_in} + {1'b0, bus.sb_in};
  assign dif       = {1'b0, bus.sa_in} - {1'b0, bus.sb_in};
  assign shift_big = ({1'b0, bus.sb_in} >= SHIFT_LIMIT);

`ifdef ALU_PIPE_SAT_EN
  // Overflow direction always follows the sign of A for both add and sub.
  logic [WIDTH-1:0] sat_val;
  assign sat_val = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

  // Stage-1 datapath: result and flags from the live inputs.
  always_comb begin
    alu_c = '0;
    case (bus.op_in)
      OP_NOP: alu_c.res = bus.sa_in;
      OP_ADD: begin
        alu_c.res   = sum[WIDTH-1:0];
        alu_c.carry = sum[WIDTH];
        alu_c.ovf   = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        alu_c.res   = dif[WIDTH-1:0];
        alu_c.carry = dif[WIDTH];
        alu_c.ovf   = (a_msb != b_msb) && (dif[WIDTH-1] != a_msb);
      end
      OP_AND: alu_c.res = bus.sa_in & bus.sb_in;
      OP_OR:  alu_c.res = bus.sa_in | bus.sb_in;
      OP_XOR: alu_c.res = bus.sa_in ^ bus.sb_in;
      OP_SLL: alu_c.res = shift_big ? '0 : (bus.sa_in << bus.sb_in);
      OP_SRL: alu_c.res = shift_big ? '0 : (bus.sa_in >> bus.sb_in);
      default: alu_c.res = bus.sa_in;
    endcase
`ifdef ALU_PIPE_SAT_EN
    if (((bus.op_in == OP_ADD) || (bus.op_in == OP_SUB)) && alu_c.ovf) begin
      alu_c.res = sat_val;
    end
`endif
    alu_c.zero = (alu_c.res == '0);
  end

  // A stage may load when it is empty or its content moves on; walk back from the output.
  always_comb begin : ld_chain
    logic nxt;
    nxt = bus.ready_in;
    ld  = '0;
    for (int k = STAGES; k >= 1; k--) begin
      nxt   = !vld[k] || nxt;
      ld[k] = nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        stg[k] <= '0;
      end
    end else begin
      if (ld[1]) begin
        vld[1] <= bus.valid_in;
        if (bus.valid_in) begin
          stg[1] <= alu_c;
        end
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (ld[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            stg[k] <= stg[k-1];
          end
        end
      end
    end
  end

  assign bus.ready_out = ld[1];
  assign bus.valid_out = vld[STAGES];
  assign bus.out       = stg[STAGES].res;
  assign bus.carry_out = stg[STAGES].carry;
  assign bus.ovf_out   = stg[STAGES].ovf;
  assign bus.zero_out  = stg[STAGES].zero;

endmodule
